// File: rtl/wb_light_sched.sv
// wb_light_sched: Wishbone slave that schedules the aquarium lighting channel.
// It keeps a seconds-of-day clock and ramps an 8-bit light level up at ON_TIME
// and down at OFF_TIME, or follows a manual on/off bit. The level drives a PWM
// output. Completion of each ramp raises a done pulse and a sticky status bit
// that can be routed to an interrupt.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// OFF        | light off, level held at 0
// RAMP_UP    | level stepping toward 255, one step per RAMP_DIV+1 cycles
// ON         | light fully on, level held at 255
// RAMP_DOWN  | level stepping toward 0, one step per RAMP_DIV+1 cycles

module wb_light_sched #(
    parameter int unsigned clk_freq = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_ack_o,
    output logic        signal,
    output logic        done,
    output logic        irq
);

    localparam logic [16:0] DAY_LAST   = 17'd86399;
    localparam logic [31:0] PRESC_LAST = 32'(clk_freq - 1);

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_ON        = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } state_t;

    // Registers
    logic        r_ack;
    logic [31:0] r_dat_o;
    logic [3:0]  r_ctrl;
    logic [16:0] r_on_time;
    logic [16:0] r_off_time;
    logic [23:0] r_ramp_div;
    logic [16:0] r_time;
    logic [31:0] r_presc;
    logic        r_target;
    state_t      r_state;
    logic [7:0]  r_level;
    logic [23:0] r_step_cnt;
    logic        r_done;
    logic        r_done_sticky;
    logic [7:0]  r_pwm_cnt;

    // Wires
    logic        w_access;
    logic        w_wr;
    logic [2:0]  w_idx;
    logic        w_day_ok;
    logic        w_time_load;
    logic        w_sticky_clr;
    logic        w_tick;
    logic [16:0] w_time_inc;
    logic        w_step;
    logic        w_done_evt;
    logic [31:0] w_rdata;
    logic        w_unused;

    // Byte lanes and address bits outside adr[4:2] play no part in decoding.
    assign w_unused = ^{wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0]};

    // ack is self-clearing, so a held strobe only gets one transfer per two cycles
    assign w_access     = wb_stb_i & wb_cyc_i & ~r_ack;
    assign w_wr         = w_access & wb_we_i;
    assign w_idx        = wb_adr_i[4:2];
    assign w_day_ok     = (wb_dat_i <= 32'd86399);
    assign w_time_load  = w_wr & (w_idx == 3'd4) & w_day_ok;
    assign w_sticky_clr = w_wr & (w_idx == 3'd5) & wb_dat_i[16];

    assign w_tick     = (r_presc == PRESC_LAST);
    assign w_time_inc = (r_time == DAY_LAST) ? 17'd0 : r_time + 17'd1;

    // Compare with >= so that lowering RAMP_DIV mid-ramp cannot strand the
    // counter above the new divider for a full 24-bit wrap.
    assign w_step = (r_step_cnt >= r_ramp_div);

    assign w_done_evt =
        ((r_state == ST_RAMP_UP) & r_target &
         ((r_ramp_div == 24'd0) | (w_step & (r_level == 8'hFF)))) |
        ((r_state == ST_RAMP_DOWN) & ~r_target &
         ((r_ramp_div == 24'd0) | (w_step & (r_level == 8'h00))));

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat_o;
    assign done     = r_done;
    assign irq      = r_done_sticky & r_ctrl[3];
    assign signal   = (r_level == 8'hFF) | (r_pwm_cnt < r_level);

    // Read data mux for the word addressed by the current access
    always_comb begin
        w_rdata = 32'd0;
        case (w_idx)
            3'd0:    w_rdata = {28'd0, r_ctrl};
            3'd1:    w_rdata = {15'd0, r_on_time};
            3'd2:    w_rdata = {15'd0, r_off_time};
            3'd3:    w_rdata = {8'd0, r_ramp_div};
            3'd4:    w_rdata = {15'd0, r_time};
            3'd5:    w_rdata = {15'd0, r_done_sticky, r_level, 6'd0, r_state};
            default: w_rdata = 32'd0;
        endcase
    end

    // Bus handshake: one-cycle ack, read data captured on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack   <= 1'b0;
            r_dat_o <= 32'd0;
        end else begin
            r_ack   <= w_access;
            r_dat_o <= w_access ? w_rdata : 32'd0;
        end
    end

    // Configuration registers; out-of-day time values are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl     <= 4'd0;
            r_on_time  <= 17'd0;
            r_off_time <= 17'd0;
            r_ramp_div <= 24'd0;
        end else if (w_wr) begin
            case (w_idx)
                3'd0: r_ctrl <= wb_dat_i[3:0];
                3'd1: if (w_day_ok) r_on_time <= wb_dat_i[16:0];
                3'd2: if (w_day_ok) r_off_time <= wb_dat_i[16:0];
                3'd3: r_ramp_div <= wb_dat_i[23:0];
                default: ;
            endcase
        end
    end

    // Seconds-of-day clock; a TIME write restarts the current second
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= 32'd0;
            r_time  <= 17'd0;
        end else if (w_time_load) begin
            r_presc <= 32'd0;
            r_time  <= wb_dat_i[16:0];
        end else if (w_tick) begin
            r_presc <= 32'd0;
            r_time  <= w_time_inc;
        end else begin
            r_presc <= r_presc + 32'd1;
        end
    end

    // Light-wanted flag; schedule compares only happen on an unpreempted tick
    always_ff @(posedge clk) begin
        if (rst) begin
            r_target <= 1'b0;
        end else if (!r_ctrl[0]) begin
            r_target <= 1'b0;
        end else if (r_ctrl[1]) begin
            r_target <= r_ctrl[2];
        end else if (w_tick && !w_time_load && (r_on_time != r_off_time)) begin
            if (w_time_inc == r_on_time)
                r_target <= 1'b1;
            else if (w_time_inc == r_off_time)
                r_target <= 1'b0;
        end
    end

    // Ramp state machine with level stepping and completion reporting
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_OFF;
            r_level       <= 8'd0;
            r_step_cnt    <= 24'd0;
            r_done        <= 1'b0;
            r_done_sticky <= 1'b0;
        end else begin
            r_done <= w_done_evt;
            if (w_done_evt)
                r_done_sticky <= 1'b1;
            else if (w_sticky_clr)
                r_done_sticky <= 1'b0;

            case (r_state)
                ST_OFF: begin
                    if (r_target) begin
                        r_state    <= ST_RAMP_UP;
                        r_step_cnt <= 24'd0;
                    end
                end
                ST_ON: begin
                    if (!r_target) begin
                        r_state    <= ST_RAMP_DOWN;
                        r_step_cnt <= 24'd0;
                    end
                end
                ST_RAMP_UP: begin
                    if (!r_target) begin
                        r_state    <= ST_RAMP_DOWN;
                        r_step_cnt <= 24'd0;
                    end else if (r_ramp_div == 24'd0) begin
                        r_level <= 8'hFF;
                        r_state <= ST_ON;
                    end else if (w_step) begin
                        r_step_cnt <= 24'd0;
                        if (r_level == 8'hFF)
                            r_state <= ST_ON;
                        else
                            r_level <= r_level + 8'd1;
                    end else begin
                        r_step_cnt <= r_step_cnt + 24'd1;
                    end
                end
                ST_RAMP_DOWN: begin
                    if (r_target) begin
                        r_state    <= ST_RAMP_UP;
                        r_step_cnt <= 24'd0;
                    end else if (r_ramp_div == 24'd0) begin
                        r_level <= 8'h00;
                        r_state <= ST_OFF;
                    end else if (w_step) begin
                        r_step_cnt <= 24'd0;
                        if (r_level == 8'h00)
                            r_state <= ST_OFF;
                        else
                            r_level <= r_level - 8'd1;
                    end else begin
                        r_step_cnt <= r_step_cnt + 24'd1;
                    end
                end
                default: r_state <= ST_OFF;
            endcase
        end
    end

    // Free-running PWM phase counter
    always_ff @(posedge clk) begin
        if (rst)
            r_pwm_cnt <= 8'd0;
        else
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
    end

endmodule

// File: tb/tb_wb_light_sched.sv
// Bench for wb_light_sched: register access vectors, then scheduled sunrise,
// sunset with interrupt, ramp reversal, day wrap, PWM duty and reset mid-ramp.
module tb_wb_light_sched;

    localparam int CF = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_stb_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [3:0]  wb_sel_i = 4'hF;
    logic        wb_ack_o;
    logic        signal;
    logic        done;
    logic        irq;

    wb_light_sched #(.clk_freq(CF)) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_stb_i (wb_stb_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_we_i  (wb_we_i),
        .wb_sel_i (wb_sel_i),
        .wb_ack_o (wb_ack_o),
        .signal   (signal),
        .done     (done),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far; read it at least 1ns after an edge.
    int ncyc = 0;
    always @(posedge clk) ncyc <= ncyc + 1;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0]  idx;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run_to(input int n);
        while (ncyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bus access; ack_edge is the edge number on which ack rose.
    task automatic bus(input logic we, input logic [2:0] idx, input logic [31:0] wd,
                       output logic [31:0] rd, output int ack_edge);
        @(negedge clk);
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = {27'd0, idx, 2'b00};
        wb_dat_i = wd;
        @(posedge clk);
        #1;
        ack_edge = ncyc;
        chk("ack_rise", wb_ack_o, 1);
        rd = wb_dat_o;
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
        @(posedge clk);
        #1;
        chk("ack_fall", wb_ack_o, 0);
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] wd, output int ack_edge);
        logic [31:0] dummy;
        bus(1'b1, idx, wd, dummy, ack_edge);
    endtask

    task automatic rd(input logic [2:0] idx, output logic [31:0] data);
        int e;
        bus(1'b0, idx, 32'd0, data, e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int e, pw, pt, pm, pc, base, ones;
        int ks[4];
        int kl[4];

        vecs[0]  = '{3'd0, 32'h0000000F, 32'h0000000F, "ctrl_all"};
        vecs[1]  = '{3'd3, 32'h00123456, 32'h00123456, "ramp_div"};
        vecs[2]  = '{3'd1, 32'd1000,     32'd1000,     "on_time"};
        vecs[3]  = '{3'd1, 32'h0001FFFF, 32'd1000,     "on_time_big"};
        vecs[4]  = '{3'd2, 32'd86399,    32'd86399,    "off_time_max"};
        vecs[5]  = '{3'd2, 32'd86400,    32'd86399,    "off_time_86400"};
        vecs[6]  = '{3'd4, 32'd100,      32'd100,      "time"};
        vecs[7]  = '{3'd4, 32'd86400,    32'd100,      "time_86400"};
        vecs[8]  = '{3'd0, 32'hFFFFFFF0, 32'h00000000, "ctrl_upper"};
        vecs[9]  = '{3'd3, 32'hFFFFFFFF, 32'h00FFFFFF, "ramp_div_mask"};
        vecs[10] = '{3'd6, 32'hFFFFFFFF, 32'h00000000, "idx6"};
        vecs[11] = '{3'd7, 32'h12345678, 32'h00000000, "idx7"};

        // Reset state
        do_reset();
        chk("rst_ack", wb_ack_o, 0);
        chk("rst_dat", wb_dat_o, 0);
        chk("rst_signal", signal, 0);
        chk("rst_done", done, 0);
        chk("rst_irq", irq, 0);
        rd(3'd5, d); chk("rst_status", d, 0);
        rd(3'd0, d); chk("rst_ctrl", d, 0);

        // Register access vectors
        foreach (vecs[i]) begin
            wr(vecs[i].idx, vecs[i].wdata, e);
            rd(vecs[i].idx, d);
            chk(vecs[i].name, d, vecs[i].exp);
        end

        // Sunrise at ON_TIME=5, RAMP_DIV=1, auto mode
        do_reset();
        wr(3'd0, 32'd1, e);
        wr(3'd3, 32'd1, e);
        wr(3'd1, 32'd5, e);
        wr(3'd4, 32'd4, pw);
        base = pw + 17;
        run_to(pw + 16); rd(3'd5, d); chk("rise_before", d, 32'h0);
        run_to(base + 1); rd(3'd5, d); chk("rise_entry", d, 32'h1);
        ks[0] = 3;   kl[0] = 1;
        ks[1] = 5;   kl[1] = 2;
        ks[2] = 200; kl[2] = 100;
        ks[3] = 509; kl[3] = 254;
        foreach (ks[i]) begin
            run_to(base + ks[i]);
            rd(3'd5, d);
            chk("rise_level", d, {16'd0, 8'(kl[i]), 8'h01});
        end
        run_to(base + 511); chk("rise_done_early", done, 0);
        run_to(base + 512); chk("rise_done", done, 1); chk("rise_irq", irq, 0);
        run_to(base + 513); chk("rise_done_len", done, 0);
        rd(3'd5, d); chk("rise_status", d, 32'h0001FF02);
        chk("rise_signal", signal, 1);

        // Sunset with interrupt enabled
        wr(3'd4, 32'd50, pt);
        wr(3'd5, 32'h00010000, e);
        wr(3'd2, 32'd52, e);
        wr(3'd0, 32'd9, e);
        chk("set_irq_clr", irq, 0);
        base = pt + 33;
        run_to(base + 1);   rd(3'd5, d); chk("set_entry", d, 32'h0000FF03);
        run_to(base + 201); rd(3'd5, d); chk("set_level", d, 32'h00009B03);
        run_to(base + 511); chk("set_done_early", done, 0); chk("set_irq_early", irq, 0);
        run_to(base + 512); chk("set_done", done, 1); chk("set_irq", irq, 1);
        run_to(base + 513); chk("set_done_len", done, 0); chk("set_irq_hold", irq, 1);
        chk("set_signal", signal, 0);
        rd(3'd5, d); chk("set_status", d, 32'h00010000);
        wr(3'd5, 32'h00010000, e);
        chk("set_irq_wclr", irq, 0);

        // Reversal mid-ramp at level 100
        do_reset();
        wr(3'd3, 32'd1, e);
        wr(3'd0, 32'd7, pm);
        base = pm + 2;
        run_to(base + 150); rd(3'd5, d); chk("rev_up", d, 32'h00004B01);
        run_to(base + 198); wr(3'd0, 32'd0, e);
        base = base + 201;
        run_to(base + 1);   rd(3'd5, d); chk("rev_turn", d, 32'h00006403);
        run_to(base + 11);  rd(3'd5, d); chk("rev_dec", d, 32'h00005F03);
        run_to(base + 149); rd(3'd5, d); chk("rev_low", d, 32'h00001A03);
        run_to(base + 201); chk("rev_done_early", done, 0);
        run_to(base + 202); chk("rev_done", done, 1);
        rd(3'd5, d); chk("rev_status", d, 32'h00010000);

        // Day wrap and manual full-on with RAMP_DIV=0
        do_reset();
        wr(3'd4, 32'd86399, pt);
        wr(3'd0, 32'd7, e);
        run_to(pt + 4);  rd(3'd5, d); chk("man_entry", d, 32'h1);
        run_to(pt + 6);  rd(3'd5, d); chk("man_on", d, 32'h0001FF02);
        run_to(pt + 13); rd(3'd4, d); chk("wrap_before", d, 32'd86399);
        run_to(pt + 16); rd(3'd4, d); chk("wrap_after", d, 32'd0);
        ones = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (signal === 1'b1) ones++;
        end
        chk("pwm_full", ones, 300);

        // PWM duty at level 64: freeze the ramp by raising RAMP_DIV
        do_reset();
        wr(3'd3, 32'd1, e);
        wr(3'd0, 32'd7, pc);
        base = pc + 2;
        run_to(base + 128); wr(3'd3, 32'h00FFFFFF, e);
        rd(3'd5, d); chk("pwm_level64", d, 32'h00004001);
        ones = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (signal === 1'b1) ones++;
        end
        chk("pwm_duty64", ones, 64);

        // Reset asserted mid-ramp
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_signal", signal, 0);
        chk("mrst_done", done, 0);
        chk("mrst_irq", irq, 0);
        @(negedge clk);
        rst = 1'b0;
        rd(3'd5, d); chk("mrst_status", d, 0);
        rd(3'd0, d); chk("mrst_ctrl", d, 0);
        rd(3'd3, d); chk("mrst_div", d, 0);
        rd(3'd1, d); chk("mrst_on", d, 0);
        rd(3'd2, d); chk("mrst_off", d, 0);
        rd(3'd4, d); chk("mrst_time", d, 0);
        chk("mrst_signal_after", signal, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
